// File: rtl/mul_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// mul_seq_ctrl_if : host byte port, control/status and multiplier-side bundle
//                   for mul_seq_ctrl.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mul_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 ena;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 abort;
    logic                 acc_mode;
    logic                 busy;
    logic                 err_ovr;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_result;

    // Sequencer side
    modport slave (
        input  ena, in_data, in_valid, out_ready, abort, acc_mode,
               mul_done, mul_result,
        output in_ready, out_data, out_valid, busy, err_ovr,
               mul_a, mul_b, mul_start
    );

    // Host / multiplier side
    modport master (
        output ena, in_data, in_valid, out_ready, abort, acc_mode,
               mul_done, mul_result,
        input  in_ready, out_data, out_valid, busy, err_ovr,
               mul_a, mul_b, mul_start
    );
endinterface

`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
//------------------------------------------------------------------------------
// mul_seq_ctrl : byte-serial operand loader / product streamer around a shared
//                multiplier. Optional accumulate path: MUL_SEQ_ACCUM_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_seq_ctrl_if.slave    bus
);

    localparam int NB = WIDTH / 8;
    localparam int CW = $clog2(2 * NB);

    localparam logic [CW-1:0] C_LAST_OP  = CW'(NB - 1);
    localparam logic [CW-1:0] C_LAST_RES = CW'(2 * NB - 1);

    typedef enum logic [2:0] {
        S_LOAD_A = 3'd0,
        S_LOAD_B = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_SEND   = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 err_q, err_d;

    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic [7:0]           w_out_byte;
    logic [2*WIDTH-1:0]   w_result;

`ifdef MUL_SEQ_ACCUM_EN
    logic                 acc_mode_q, acc_mode_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    assign w_result = acc_mode_q ? (acc_q + bus.mul_result) : bus.mul_result;
`else
    logic                 unused_acc_mode;

    assign unused_acc_mode = bus.acc_mode;
    assign w_result        = bus.mul_result;
`endif

    assign w_in_ready  = bus.ena && ((state_q == S_LOAD_A) || (state_q == S_LOAD_B));
    assign w_out_valid = bus.ena && (state_q == S_SEND);
    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_xfer      = w_out_valid && bus.out_ready;

    always_comb begin
        w_out_byte = '0;
        for (int j = 0; j < 2 * NB; j++) begin
            if (cnt_q == CW'(j)) begin
                w_out_byte = res_q[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        res_d   = res_q;
        err_d   = err_q;
`ifdef MUL_SEQ_ACCUM_EN
        acc_mode_d = acc_mode_q;
        acc_d      = acc_q;
`endif

        // A done pulse is only expected while a multiply is outstanding
        if (bus.mul_done && (state_q != S_WAIT) && (state_q != S_DRAIN)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_LOAD_A: begin
                if (bus.abort) begin
                    cnt_d = '0;
                end else if (w_accept) begin
                    for (int k = 0; k < NB; k++) begin
                        if (cnt_q == CW'(k)) begin
                            mul_a_d[8*k +: 8] = bus.in_data;
                        end
                    end
                    if (cnt_q == C_LAST_OP) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_LOAD_B: begin
                if (bus.abort) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_A;
                end else if (w_accept) begin
                    for (int k = 0; k < NB; k++) begin
                        if (cnt_q == CW'(k)) begin
                            mul_b_d[8*k +: 8] = bus.in_data;
                        end
                    end
                    if (cnt_q == C_LAST_OP) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_START: begin
`ifdef MUL_SEQ_ACCUM_EN
                acc_mode_d = bus.acc_mode;
`endif
                state_d = bus.abort ? S_DRAIN : S_WAIT;
            end

            S_WAIT: begin
                // A done coinciding with abort completes the drain directly
                if (bus.mul_done) begin
                    state_d = S_LOAD_A;
                    if (!bus.abort) begin
                        res_d   = w_result;
                        state_d = S_SEND;
`ifdef MUL_SEQ_ACCUM_EN
                        acc_d   = w_result;
`endif
                    end
                end else if (bus.abort) begin
                    state_d = S_DRAIN;
                end
            end

            S_SEND: begin
                if (bus.abort) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_A;
                end else if (w_xfer) begin
                    if (cnt_q == C_LAST_RES) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_A;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (bus.mul_done) begin
                    state_d = S_LOAD_A;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD_A;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifdef MUL_SEQ_ACCUM_EN
            acc_mode_q <= 1'b0;
            acc_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            res_q   <= res_d;
            err_q   <= err_d;
`ifdef MUL_SEQ_ACCUM_EN
            acc_mode_q <= acc_mode_d;
            acc_q      <= acc_d;
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_byte;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_start = (state_q == S_START);
    assign bus.busy      = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign bus.err_ovr   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
//------------------------------------------------------------------------------
// tb_mul_seq_ctrl : directed vector bench for mul_seq_ctrl with a latency-
//                   programmable multiplier model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mul_seq_ctrl_if #(.WIDTH(32)) bus ();

    mul_seq_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp   = 0;
    int n_err   = 0;
    int n_start = 0;

    // Multiplier model: done pulse mdl_lat cycles after the start cycle
    int          mdl_lat    = 3;
    int          mdl_cnt    = 0;
    int          stray_req  = 0;
    int          stray_seen = 0;
    logic        mdl_done;
    logic [63:0] mdl_prod   = '0;

    initial begin
        bus.mul_done   = 1'b0;
        bus.mul_result = '0;
    end

    always begin
        @(negedge clk);
        mdl_done = 1'b0;
        if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) mdl_done = 1'b1;
        end
        if (stray_req != stray_seen) begin
            stray_seen = stray_req;
            mdl_done   = 1'b1;
        end
        if (bus.mul_start === 1'b1) begin
            mdl_cnt  = mdl_lat;
            mdl_prod = {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
        end
        bus.mul_done   = mdl_done;
        bus.mul_result = mdl_prod;
    end

    always @(posedge clk) begin
        if (bus.mul_start === 1'b1) n_start++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Presents A then B, one byte per cycle; returns at the negedge of the START cycle.
    task automatic load_ops(input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = a[8*k +: 8];
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = b[8*k +: 8];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic recv(input logic [63:0] exp, input int mode, input int gap_at, input string tag);
        logic [63:0] got_v    = '0;
        int          got      = 0;
        int          cyc      = 0;
        bit          stalled  = 0;
        bit          gap_done = 0;
        logic [7:0]  prev     = '0;
        logic [3:0]  pat      = 4'b1001;
        logic        rdy;
        while (got < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                chk({tag, " hold valid"}, bus.out_valid, 1);
                chk({tag, " hold data"}, bus.out_data, prev);
            end
            if (gap_at >= 0 && got == gap_at && !gap_done && bus.out_valid) begin
                gap_done      = 1;
                stalled       = 0;
                bus.ena       = 1'b0;
                bus.out_ready = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk({tag, " ena0 out_valid"}, bus.out_valid, 0);
                end
                bus.out_ready = 1'b0;
                bus.ena       = 1'b1;
                continue;
            end
            rdy = (mode == 1) ? pat[cyc % 4] : 1'b1;
            bus.out_ready = rdy;
            if (bus.out_valid) begin
                if (rdy) begin
                    got_v[8*got +: 8] = bus.out_data;
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev    = bus.out_data;
                end
            end else begin
                stalled = 0;
            end
        end
        if (got < 8) chk({tag, " bytes before timeout"}, got, 8);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, " product"}, got_v, exp);
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic acc,
                           input logic [63:0] exp, input int mode, input int gap_at,
                           input string tag);
        int s0 = n_start;
        bus.acc_mode = acc;
        load_ops(a, b);
        chk({tag, " mul_start at T+1"}, bus.mul_start, 1);
        chk({tag, " mul_a"}, bus.mul_a, a);
        chk({tag, " mul_b"}, bus.mul_b, b);
        recv(exp, mode, gap_at, tag);
        chk({tag, " in_ready after"}, bus.in_ready, 1);
        chk({tag, " busy after"}, bus.busy, 0);
        chk({tag, " start count"}, n_start - s0, 1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          mode;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h0000_0002, 32'h0000_0003, 0, 64'h0000_0000_0000_0006};
        vecs[3] = '{32'h0001_0000, 32'h0001_0000, 0, 64'h0000_0001_0000_0000};
        vecs[4] = '{32'h1234_5678, 32'h0000_0010, 1, 64'h0000_0001_2345_6780};
        vecs[5] = '{32'h8000_0000, 32'h0000_0002, 0, 64'h0000_0001_0000_0000};
        vecs[6] = '{32'h0000_0000, 32'hDEAD_BEEF, 0, 64'h0000_0000_0000_0000};
        vecs[7] = '{32'h0000_00FF, 32'h0000_0101, 1, 64'h0000_0000_0000_FFFF};

        rst_n         = 1'b0;
        bus.ena       = 1'b1;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.abort     = 1'b0;
        bus.acc_mode  = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset mul_start", bus.mul_start, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset err_ovr", bus.err_ovr, 0);
        chk("reset mul_a", bus.mul_a, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp, vecs[i].mode, -1,
                    $sformatf("vec%0d", i));
        end

        // ena dropped during SEND after 3 bytes
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, 3, "ena_gap");

        // abort in the cycle after mul_start, done arrives 5 cycles later
        mdl_lat = 6;
        load_ops(32'h0102_0304, 32'h0506_0708);
        chk("abwait mul_start", bus.mul_start, 1);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abwait busy", bus.busy, 1);
        for (int i = 3; i <= 7; i++) begin
            if (i > 3) @(negedge clk);
            chk($sformatf("abwait in_ready T+%0d", i), bus.in_ready, 0);
            chk($sformatf("abwait out_valid T+%0d", i), bus.out_valid, 0);
        end
        @(negedge clk);
        chk("abwait in_ready rise", bus.in_ready, 1);
        chk("abwait err_ovr", bus.err_ovr, 0);
        mdl_lat = 3;

        // abort in START: start still issued, then drain
        load_ops(32'h0A0B_0C0D, 32'h0506_0708);
        bus.abort = 1'b1;
        chk("abstart mul_start", bus.mul_start, 1);
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abstart busy", bus.busy, 1);
        chk("abstart single start", bus.mul_start, 0);
        repeat (2) begin
            @(negedge clk);
            chk("abstart in_ready low", bus.in_ready, 0);
            chk("abstart out_valid", bus.out_valid, 0);
        end
        @(negedge clk);
        chk("abstart in_ready rise", bus.in_ready, 1);
        chk("abstart err_ovr", bus.err_ovr, 0);

        // abort in LOAD_B beats a same-cycle byte; operands kept, counter cleared
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h44 - 8'(k * 8'h11);
        end
        @(negedge clk);
        bus.in_data = 8'h55;
        @(negedge clk);
        bus.in_data = 8'h66;
        @(negedge clk);
        bus.in_data = 8'hAA;
        bus.abort   = 1'b1;
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        chk("abload in_ready", bus.in_ready, 1);
        chk("abload mul_a kept", bus.mul_a, 32'h1122_3344);
        chk("abload mul_b partial", bus.mul_b, 32'h0506_6655);
        run_txn(32'h0000_0007, 32'h0000_0009, 1'b0, 64'h3F, 0, -1, "after_abload");

        // stray done is sticky until reset
        @(negedge clk);
        stray_req++;
        repeat (3) @(negedge clk);
        chk("stray err_ovr set", bus.err_ovr, 1);
        run_txn(32'h0000_0002, 32'h0000_0003, 1'b0, 64'h6, 0, -1, "stray_txn");
        chk("stray err_ovr sticky", bus.err_ovr, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("stray err_ovr reset", bus.err_ovr, 0);
        rst_n = 1'b1;

`ifdef MUL_SEQ_ACCUM_EN
        run_txn(32'h0000_0002, 32'h0000_0003, 1'b0, 64'h06, 0, -1, "acc_load");
        run_txn(32'h0000_0004, 32'h0000_0005, 1'b1, 64'h1A, 0, -1, "acc_add");
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Byte-serial sequencer wrapped around the shared high-speed multiplier datapath. It collects two WIDTH-bit operands one byte at a time over a valid/ready host port and issues a single-cycle start to the multiplier. It then waits for the multiplier's done pulse and streams the 2*WIDTH-bit product back out, LSB byte first. It sits between the pin-level I/O mux and the multiplier core.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 8; NB = WIDTH/8.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; gates the host handshakes only
in_data  input  8  operand byte
in_valid  input  1  host offers in_data
in_ready  output  1  block accepts a byte this cycle
out_data  output  8  product byte
out_valid  output  1  out_data valid
out_ready  input  1  host takes out_data
abort  input  1  synchronous abort of the current transaction
acc_mode  input  1  accumulate select; used only with MUL_SEQ_ACCUM_EN
busy  output  1  high in START, WAIT or DRAIN
err_ovr  output  1  sticky: unexpected mul_done
mul_a  output  WIDTH  operand A to multiplier
mul_b  output  WIDTH  operand B to multiplier
mul_start  output  1  one-cycle start pulse
mul_done  input  1  one-cycle result-valid pulse from multiplier
mul_result  input  2*WIDTH  product, valid when mul_done=1

Behaviour:
- One clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state=LOAD_A; byte counter, mul_a, mul_b, result register, accumulator and err_ovr all 0. After reset in_ready=ena; out_valid=0, mul_start=0, busy=0.
- States are LOAD_A, LOAD_B, START, WAIT, SEND and DRAIN.
- in_ready = ena and (state is LOAD_A or LOAD_B). A byte is accepted on a cycle where in_valid and in_ready are both 1.
- LOAD_A: an accepted byte k (k = 0..NB-1, LSB first) is written to mul_a[8k+7:8k]. After byte NB-1 the counter clears and state goes to LOAD_B.
- LOAD_B: loads mul_b the same way. After byte NB-1 state goes to START.
- START: mul_start=1 for exactly this one cycle, then state goes to WAIT. acc_mode is sampled here.
- Latency: if the last B byte is accepted in cycle T, mul_start is high in cycle T+1.
- mul_a and mul_b are registers. They change only on accepted bytes, so they are stable from START through WAIT.
- WAIT: stays until mul_done=1. mul_result is then captured into the result register and state goes to SEND. out_valid rises the cycle after mul_done. WAIT and DRAIN respond to mul_done even when ena=0.
- SEND: out_valid = ena. out_data = result byte j, with j = 0..2*NB-1, LSB first.
- SEND transfer: on out_valid and out_ready, j increments. After the transfer of j = 2*NB-1, j clears and state returns to LOAD_A.
- Back-pressure: while out_valid=1 and out_ready=0, out_data and j hold.
- mul_done while state is not WAIT or DRAIN: err_ovr is set and the pulse is otherwise ignored. err_ovr clears only on reset.
- abort from LOAD_A, LOAD_B or SEND: go to LOAD_A next cycle; counters clear; mul_a and mul_b keep their contents.
- abort from START: mul_start is still issued this cycle, then state goes to DRAIN.
- abort from WAIT: go to DRAIN.
- DRAIN: wait for mul_done, discard the result, then go to LOAD_A; err_ovr is not set.
- abort while already in DRAIN: ignored.
- abort has priority over a same-cycle byte accept or out transfer; that byte or transfer is not counted.
- mul_done arriving in the same cycle as an abort in WAIT counts as the DRAIN completion: next state is LOAD_A, no error.
- ena=0: host handshakes are suppressed (in_ready=0, out_valid=0). State and counters hold except for the WAIT/DRAIN transitions above.

Optional Feature:
Macro: MUL_SEQ_ACCUM_EN.
- Defined:
  - acc_mode=1 at START: the SEND value is accumulator + mul_result, modulo 2^(2*WIDTH), and that sum is also written to the accumulator.
  - acc_mode=0 at START: the SEND value is mul_result and the accumulator is loaded with mul_result.
  - The accumulator is cleared only by reset; abort and DRAIN leave it unchanged.
- Not defined: no accumulator register; acc_mode is ignored; the SEND value is always mul_result.

Test Plan:
- WIDTH=32 basic product: A bytes FF FF FF FF, B bytes FF FF FF FF, multiplier model with 3-cycle latency -> exactly one mul_start, one cycle after the 8th byte; out bytes 01 00 00 00 FE FF FF FF; state back in LOAD_A with in_ready=1.
- Back-pressure: same product with out_ready toggled 1,0,0,1 repeatedly -> out_data held while stalled; exactly 8 bytes delivered, unchanged, in order.
- Abort in WAIT: abort in the cycle after mul_start; model's mul_done arrives 5 cycles later -> no out_valid, err_ovr=0, in_ready rises the cycle after mul_done.
- Stray done: pulse mul_done in LOAD_A -> err_ovr=1 and stays 1 through a following normal 2x3=6 transaction; only rst_n low clears it.
- ena=0 during SEND after 3 bytes -> out_valid=0 and j holds; ena=1 -> remaining 5 bytes delivered correctly.
- MUL_SEQ_ACCUM_EN: A=2, B=3, acc_mode=0 -> out 06 00..00; then A=4, B=5, acc_mode=1 -> out 1A 00..00.
